// File: rtl/window_fetch3.sv
// window_fetch3: fetches the 3x3 neighbourhood of an event address from a 1-cycle-latency frame memory and
// issues it as one packed window. Define WINDOW_BORDER_REPLICATE_EN to clamp (replicate) borders instead of zero-fill.
module window_fetch3 #(
    parameter int DATA_WIDTH = 14,
    parameter int IMG_W      = 128,
    parameter int IMG_H      = 128
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_event_valid,
    input  logic [15:0]             in_event_addr,
    output logic                    in_event_ready,
    output logic                    mem_rd_en,
    output logic [15:0]             mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data,
    input  logic                    window_req,
    output logic [DATA_WIDTH*9-1:0] out_window_value,
    output logic                    out_window_valid,
    output logic [15:0]             out_window_addr,
    output logic                    out_addr_err,
    output logic [15:0]             out_window_count
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_ISSUE} state_t;

    // One spare bit over the 9-bit signed range so a 256-wide image still compares correctly.
    localparam logic signed [9:0] LIM_W = 10'(IMG_W);
    localparam logic signed [9:0] LIM_H = 10'(IMG_H);

    state_t                  state, state_nxt;
    logic [3:0]              k;
    logic [7:0]              ev_row, ev_col;
    logic [1:0]              pos_r, pos_c;
    logic signed [9:0]       pr, pc;
    logic                    row_in, col_in, ev_in_range, rd_en;
    logic [7:0]              rd_row, rd_col;
    logic                    pend_wr, pend_rd;
    logic [3:0]              pend_slot;
    logic [DATA_WIDTH-1:0]   slot_q [9];
    logic [DATA_WIDTH*9-1:0] window_packed;

    assign ev_in_range    = (int'(in_event_addr[7:0]) < IMG_W) && (int'(in_event_addr[15:8]) < IMG_H);
    assign in_event_ready = (state == S_IDLE);

    // Window position of the current fetch step: k = 3*r + c.
    assign pos_r = (k >= 4'd6) ? 2'd2 : (k >= 4'd3) ? 2'd1 : 2'd0;
    assign pos_c = 2'(k - ({1'b0, pos_r, 1'b0} + {2'b00, pos_r}));

    assign pr     = $signed({2'b00, ev_row}) + $signed({8'd0, pos_r}) - 10'sd1;
    assign pc     = $signed({2'b00, ev_col}) + $signed({8'd0, pos_c}) - 10'sd1;
    assign row_in = (pr >= 10'sd0) && (pr < LIM_H);
    assign col_in = (pc >= 10'sd0) && (pc < LIM_W);

`ifdef WINDOW_BORDER_REPLICATE_EN
    assign rd_row = row_in ? pr[7:0] : (pr < 10'sd0) ? 8'd0 : 8'(IMG_H - 1);
    assign rd_col = col_in ? pc[7:0] : (pc < 10'sd0) ? 8'd0 : 8'(IMG_W - 1);
    assign rd_en  = (state == S_FETCH);
`else
    assign rd_row = pr[7:0];
    assign rd_col = pc[7:0];
    assign rd_en  = (state == S_FETCH) && row_in && col_in;
`endif

    assign mem_rd_en   = rd_en;
    assign mem_rd_addr = rd_en ? {rd_row, rd_col} : 16'h0000;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_event_valid && ev_in_range) state_nxt = S_FETCH;
            S_FETCH: if (k == 4'd8) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_ISSUE;
            S_ISSUE: if (window_req) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        window_packed = '0;
        for (int i = 0; i < 9; i++) begin
            window_packed[DATA_WIDTH*i +: DATA_WIDTH] = slot_q[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            k                <= 4'd0;
            ev_row           <= 8'd0;
            ev_col           <= 8'd0;
            pend_wr          <= 1'b0;
            pend_rd          <= 1'b0;
            pend_slot        <= 4'd0;
            out_window_value <= '0;
            out_window_valid <= 1'b0;
            out_window_addr  <= 16'h0000;
            out_addr_err     <= 1'b0;
            out_window_count <= 16'h0000;
        end else begin
            state            <= state_nxt;
            k                <= (state == S_FETCH) ? k + 4'd1 : 4'd0;
            out_addr_err     <= (state == S_IDLE) && in_event_valid && !ev_in_range;
            out_window_valid <= 1'b0;
            // Read data arrives one cycle after the strobe, so the slot index travels with it.
            pend_wr          <= (state == S_FETCH);
            pend_rd          <= rd_en;
            pend_slot        <= k;
            if (state == S_IDLE && in_event_valid && ev_in_range) begin
                ev_row <= in_event_addr[15:8];
                ev_col <= in_event_addr[7:0];
            end
            if (state == S_ISSUE && window_req) begin
                out_window_valid <= 1'b1;
                out_window_value <= window_packed;
                out_window_addr  <= {ev_row, ev_col};
                out_window_count <= out_window_count + 16'd1;
            end
        end
    end

    // NOTE: the slot array has no reset; all nine slots are rewritten by every fetch before they are issued.
    always_ff @(posedge clk) begin
        if (pend_wr) begin
            slot_q[pend_slot] <= pend_rd ? mem_rd_data : '0;
        end
    end

endmodule
